splitter_line_decoder: RTL and testbench

//  Upstream of the beam tracker. Converts the raw ASCII puzzle stream, one byte per cycle,

---
 rtl/aoc25_7_pkg.sv | 40 ++++
 rtl/splitter_line_decoder.sv | 144 ++++++++++++++
 tb/tb_splitter_line_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aoc25_7_pkg.sv
// Shared definitions for the splitter line decoder: ASCII constants, FSM states, byte classes.
// SPLITTER_LINE_DECODER_CRLF_EN: when defined, carriage returns are silently ignored.
package aoc25_7_pkg;

  localparam logic [7:0] CHAR_DOT   = 8'h2E;  // '.'
  localparam logic [7:0] CHAR_SPLIT = 8'h5E;  // '^'
  localparam logic [7:0] CHAR_START = 8'h53;  // 'S'
  localparam logic [7:0] CHAR_LF    = 8'h0A;  // '\n'
  localparam logic [7:0] CHAR_CR    = 8'h0D;  // '\r'

  typedef enum logic {
    ST_LINE = 1'b0,
    ST_DONE = 1'b1
  } decoder_state_t;

  typedef enum logic [2:0] {
    CC_DOT    = 3'd0,  // advances the column, no splitter
    CC_SPLIT  = 3'd1,  // advances the column, marks a splitter
    CC_LF     = 3'd2,  // terminates the row
    CC_IGNORE = 3'd3,  // consumed with no effect
    CC_BAD    = 3'd4   // illegal byte, otherwise behaves like CC_DOT
  } char_class_t;

  function automatic char_class_t classify_char(input logic [7:0] ch);
    char_class_t cls;
    case (ch)
      CHAR_DOT, CHAR_START: cls = CC_DOT;
      CHAR_SPLIT:           cls = CC_SPLIT;
      CHAR_LF:              cls = CC_LF;
`ifdef SPLITTER_LINE_DECODER_CRLF_EN
      CHAR_CR:              cls = CC_IGNORE;
`else
      CHAR_CR:              cls = CC_BAD;
`endif
      default:              cls = CC_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/splitter_line_decoder.sv
// Turns an ASCII puzzle byte stream into one splitter mask per row that contains a '^'.
// SPLITTER_LINE_DECODER_CRLF_EN (see aoc25_7_pkg) makes CR bytes transparent.
module splitter_line_decoder
  import aoc25_7_pkg::*;
#(
  parameter int LINE_WIDTH  = 141,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inbound_valid,
  input  logic [7:0]             inbound_data,
  input  logic                   end_of_file,
  output logic                   line_valid,
  output logic [LINE_WIDTH-1:0]  line_data,
  output logic [COUNT_WIDTH-1:0] row_count,
  output logic [COUNT_WIDTH-1:0] emit_count,
  output logic                   done,
  output logic                   error_overflow,
  output logic                   error_char
);

  // Column counter must reach LINE_WIDTH itself, which is where it saturates.
  localparam int COL_W = $clog2(LINE_WIDTH + 1);
  localparam logic [COL_W-1:0]      COL_MAX  = COL_W'(LINE_WIDTH);
  localparam logic [LINE_WIDTH-1:0] MASK_ONE = LINE_WIDTH'(1);

  decoder_state_t          r_state;
  logic [COL_W-1:0]        r_col;
  logic [LINE_WIDTH-1:0]   r_accum;
  logic                    r_line_valid;
  logic [LINE_WIDTH-1:0]   r_line_data;
  logic [COUNT_WIDTH-1:0]  r_row_count;
  logic [COUNT_WIDTH-1:0]  r_emit_count;
  logic                    r_done;
  logic                    r_error_overflow;
  logic                    r_error_char;

  decoder_state_t          w_state_nxt;
  char_class_t             w_class;
  logic [COL_W-1:0]        w_col_nxt;
  logic [LINE_WIDTH-1:0]   w_accum_nxt;
  logic [LINE_WIDTH-1:0]   w_mask;
  logic                    w_row_end;
  logic                    w_emit;
  logic                    w_err_char;
  logic                    w_err_ovf;

  assign w_class = classify_char(inbound_data);

  // NOTE: every signal gets a default before any branch so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_accum_nxt = r_accum;
    w_mask      = r_accum;
    w_row_end   = 1'b0;
    w_err_char  = 1'b0;
    w_err_ovf   = 1'b0;

    if (r_state == ST_LINE) begin
      if (inbound_valid) begin
        case (w_class)
          CC_DOT, CC_SPLIT, CC_BAD: begin
            w_err_char = (w_class == CC_BAD);
            if (r_col == COL_MAX) begin
              w_err_ovf = 1'b1;
            end else begin
              if (w_class == CC_SPLIT) w_accum_nxt = r_accum | (MASK_ONE << r_col);
              w_col_nxt = r_col + COL_W'(1);
            end
          end
          CC_LF: begin
            w_row_end   = 1'b1;
            w_mask      = r_accum;
            w_accum_nxt = '0;
            w_col_nxt   = '0;
          end
          default: ;
        endcase
      end

      // A partial row left at end of input is flushed as though a LF had arrived,
      // including any '^' consumed in this same cycle.
      if (end_of_file) begin
        w_state_nxt = ST_DONE;
        if (!w_row_end && (w_col_nxt != '0)) begin
          w_row_end   = 1'b1;
          w_mask      = w_accum_nxt;
          w_accum_nxt = '0;
          w_col_nxt   = '0;
        end
      end
    end
  end

  assign w_emit = w_row_end && (w_mask != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LINE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col            <= '0;
      r_accum          <= '0;
      r_line_valid     <= 1'b0;
      r_line_data      <= '0;
      r_row_count      <= '0;
      r_emit_count     <= '0;
      r_done           <= 1'b0;
      r_error_overflow <= 1'b0;
      r_error_char     <= 1'b0;
    end else begin
      r_col            <= w_col_nxt;
      r_accum          <= w_accum_nxt;
      r_line_valid     <= w_emit;
      r_done           <= (w_state_nxt == ST_DONE);
      r_error_overflow <= r_error_overflow | w_err_ovf;
      r_error_char     <= r_error_char | w_err_char;
      if (w_row_end) r_row_count <= r_row_count + COUNT_WIDTH'(1);
      if (w_emit) begin
        r_line_data  <= w_mask;
        r_emit_count <= r_emit_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign line_valid     = r_line_valid;
  assign line_data      = r_line_data;
  assign row_count      = r_row_count;
  assign emit_count     = r_emit_count;
  assign done           = r_done;
  assign error_overflow = r_error_overflow;
  assign error_char     = r_error_char;

endmodule

// File: tb/tb_splitter_line_decoder.sv
// Directed bench for splitter_line_decoder at LINE_WIDTH=5; honours SPLITTER_LINE_DECODER_CRLF_EN.
module tb_splitter_line_decoder;

  localparam int LW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          inbound_valid;
  logic [7:0]    inbound_data;
  logic          end_of_file;
  logic          line_valid;
  logic [LW-1:0] line_data;
  logic [CW-1:0] row_count;
  logic [CW-1:0] emit_count;
  logic          done;
  logic          error_overflow;
  logic          error_char;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt  = 0;
  int pulse_base = 0;

  splitter_line_decoder #(.LINE_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .inbound_valid  (inbound_valid),
    .inbound_data   (inbound_data),
    .end_of_file    (end_of_file),
    .line_valid     (line_valid),
    .line_data      (line_data),
    .row_count      (row_count),
    .emit_count     (emit_count),
    .done           (done),
    .error_overflow (error_overflow),
    .error_char     (error_char)
  );

  always #5 clk = ~clk;

  // Counts line_valid pulses; reads pre-edge values at the rising edge.
  always @(posedge clk) if (line_valid === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    // Thin formatting wrapper only; each caller does its own comparison below.
    $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inbound_valid = 1'b0; inbound_data = 8'h00; end_of_file = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_base = pulse_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    inbound_valid = 1'b1; inbound_data = b;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inbound_valid = 1'b0; end_of_file = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inbound_valid = 1'b0; inbound_data = 8'h00; end_of_file = 1'b0;
    #12;
    n_tests++;
    if ({line_valid, line_data, row_count, emit_count, done, error_overflow, error_char} !== '0) begin
      n_fail++; chk("reset_outputs", {line_valid, done, error_overflow, error_char}, 0);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send_str("..S..\n.....\n..^..\n");
    idle(2);
    n_tests++; if (pulse_cnt - pulse_base !== 1) begin n_fail++; chk("t1_pulses", pulse_cnt - pulse_base, 1); end
    n_tests++; if (line_data !== 5'b00100) begin n_fail++; chk("t1_data", line_data, 5'b00100); end
    n_tests++; if (row_count !== 16'd3) begin n_fail++; chk("t1_rows", row_count, 3); end
    n_tests++; if (emit_count !== 16'd1) begin n_fail++; chk("t1_emits", emit_count, 1); end
    n_tests++; if (line_valid !== 1'b0) begin n_fail++; chk("t1_valid_low", line_valid, 0); end
    send_str("\n\n");
    idle(2);
    n_tests++; if (row_count !== 16'd5) begin n_fail++; chk("empty_rows", row_count, 5); end
    n_tests++; if (emit_count !== 16'd1) begin n_fail++; chk("empty_no_emit", emit_count, 1); end
    n_tests++; if (line_data !== 5'b00100) begin n_fail++; chk("data_held", line_data, 5'b00100); end
  endtask

  task automatic test_latency_eof();
    do_reset();
    send_str(".^.^.\n");
    @(negedge clk); inbound_valid = 1'b0; end_of_file = 1'b1;
    n_tests++; if (line_valid !== 1'b1) begin n_fail++; chk("t2_valid", line_valid, 1); end
    n_tests++; if (line_data !== 5'b01010) begin n_fail++; chk("t2_data", line_data, 5'b01010); end
    n_tests++; if (done !== 1'b0) begin n_fail++; chk("t2_done_early", done, 0); end
    @(negedge clk); end_of_file = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; chk("t2_done", done, 1); end
    n_tests++; if (line_valid !== 1'b0) begin n_fail++; chk("t2_no_extra", line_valid, 0); end
    idle(2);
    n_tests++; if (pulse_cnt - pulse_base !== 1) begin n_fail++; chk("t2_pulses", pulse_cnt - pulse_base, 1); end
    n_tests++; if (done !== 1'b1) begin n_fail++; chk("t2_done_sticky", done, 1); end
  endtask

  task automatic test_flush();
    do_reset();
    send_str("^...^");
    @(negedge clk); inbound_valid = 1'b0; end_of_file = 1'b1;
    @(negedge clk); end_of_file = 1'b0;
    n_tests++; if (line_valid !== 1'b1) begin n_fail++; chk("t3_valid", line_valid, 1); end
    n_tests++; if (line_data !== 5'b10001) begin n_fail++; chk("t3_data", line_data, 5'b10001); end
    n_tests++; if (done !== 1'b1) begin n_fail++; chk("t3_done", done, 1); end
    n_tests++; if (row_count !== 16'd1) begin n_fail++; chk("t3_rows", row_count, 1); end
    // Everything after done is ignored.
    send_str("^\n");
    @(negedge clk); inbound_valid = 1'b0; end_of_file = 1'b1;
    idle(2);
    n_tests++; if (row_count !== 16'd1 || emit_count !== 16'd1) begin n_fail++; chk("done_frozen", {row_count, emit_count}, 32'h0001_0001); end
    n_tests++; if (pulse_cnt - pulse_base !== 1) begin n_fail++; chk("done_no_pulse", pulse_cnt - pulse_base, 1); end
    // Zero-length tail: done, no emit.
    do_reset();
    @(negedge clk); end_of_file = 1'b1;
    @(negedge clk); end_of_file = 1'b0;
    n_tests++; if (done !== 1'b1 || line_valid !== 1'b0 || row_count !== 16'd0) begin n_fail++; chk("empty_tail", {done, line_valid, row_count}, 32'h2_0000); end
  endtask

  task automatic test_eof_same_cycle();
    do_reset();
    send_str(".^...");
    @(negedge clk); inbound_valid = 1'b1; inbound_data = 8'h0A; end_of_file = 1'b1;
    @(negedge clk); inbound_valid = 1'b0; end_of_file = 1'b0;
    n_tests++; if (line_valid !== 1'b1 || line_data !== 5'b00010) begin n_fail++; chk("lf_eof_pulse", {line_valid, line_data}, 6'b100010); end
    n_tests++; if (done !== 1'b1) begin n_fail++; chk("lf_eof_done", done, 1); end
    idle(2);
    n_tests++; if (row_count !== 16'd1 || pulse_cnt - pulse_base !== 1) begin n_fail++; chk("lf_eof_single", row_count, 1); end
    do_reset();
    send_str("...");
    @(negedge clk); inbound_valid = 1'b1; inbound_data = 8'h5E; end_of_file = 1'b1;
    @(negedge clk); inbound_valid = 1'b0; end_of_file = 1'b0;
    n_tests++; if (line_valid !== 1'b1 || line_data !== 5'b01000) begin n_fail++; chk("split_eof_pulse", line_data, 5'b01000); end
    n_tests++; if (row_count !== 16'd1 || done !== 1'b1) begin n_fail++; chk("split_eof_rows", row_count, 1); end
  endtask

  task automatic test_errors();
    do_reset();
    send_str("^^^^^\n");
    idle(2);
    n_tests++; if (line_data !== 5'b11111 || error_overflow !== 1'b0) begin n_fail++; chk("full_row", {error_overflow, line_data}, 6'b011111); end
    send_str("^.....\n");
    idle(2);
    n_tests++; if (error_overflow !== 1'b1) begin n_fail++; chk("t4_overflow", error_overflow, 1); end
    n_tests++; if (line_data !== 5'b00001 || error_char !== 1'b0) begin n_fail++; chk("t4_data", {error_char, line_data}, 6'b000001); end
    send_str("..x..\n");
    idle(2);
    n_tests++; if (error_char !== 1'b1) begin n_fail++; chk("t4_char", error_char, 1); end
    n_tests++; if (row_count !== 16'd3 || emit_count !== 16'd2) begin n_fail++; chk("t4_counts", {row_count, emit_count}, 32'h0003_0002); end
  endtask

  task automatic test_crlf();
    do_reset();
    send_str("..^..");
    send_byte(8'h0D);
    send_byte(8'h0A);
    idle(2);
    n_tests++; if (line_data !== 5'b00100 || pulse_cnt - pulse_base !== 1) begin n_fail++; chk("t5_data", line_data, 5'b00100); end
`ifdef SPLITTER_LINE_DECODER_CRLF_EN
    n_tests++; if (error_char !== 1'b0 || error_overflow !== 1'b0) begin n_fail++; chk("t5_errs", {error_char, error_overflow}, 2'b00); end
`else
    n_tests++; if (error_char !== 1'b1 || error_overflow !== 1'b1) begin n_fail++; chk("t5_errs", {error_char, error_overflow}, 2'b11); end
`endif
    n_tests++; if (row_count !== 16'd1) begin n_fail++; chk("t5_rows", row_count, 1); end
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    send_str("^^x");
    @(negedge clk); inbound_valid = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (error_char !== 1'b0 || row_count !== 16'd0) begin n_fail++; chk("mid_rst_async", error_char, 0); end
    @(negedge clk); rst = 1'b0;
    pulse_base = pulse_cnt;
    send_str(".^...\n");
    idle(2);
    n_tests++; if (line_data !== 5'b00010 || pulse_cnt - pulse_base !== 1) begin n_fail++; chk("t6_data", line_data, 5'b00010); end
    n_tests++; if (row_count !== 16'd1 || emit_count !== 16'd1) begin n_fail++; chk("t6_counts", {row_count, emit_count}, 32'h0001_0001); end
    n_tests++; if (error_char !== 1'b0 || error_overflow !== 1'b0 || done !== 1'b0) begin n_fail++; chk("t6_flags", {error_char, error_overflow, done}, 0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency_eof();
    test_flush();
    test_eof_same_cycle();
    test_errors();
    test_crlf();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
